// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor.
// Operands are captured on an accepted start, then DIGIT bits are summed per clock,
// LSB first, through a single carry register. The final sum, carry-out and signed
// overflow are registered on the last digit and flagged with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one digit summed per clock, count = digits already processed
// DONE  | result just registered, done high for this cycle; start accepted here too
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and an integer multiple of DIGIT");
  end

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    count;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic [DIGIT:0]   dsum;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (count == CW'(N - 1));

  // One digit of a + b_eff + carry; the digit result enters the accumulator from the top
  // so that after N digits the first digit sits at the LSB.
  assign dsum    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + (DIGIT + 1)'(carry);
  assign acc_nxt = WIDTH'({dsum[DIGIT-1:0], acc} >> DIGIT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a start in DONE chains straight into the next operation.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-digit datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      count  <= '0;
      carry  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      acc   <= '0;
      count <= '0;
      carry <= sub ? 1'b1 : cin;
      a_msb <= a[WIDTH-1];
      b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      acc   <= acc_nxt;
      count <= count + CW'(1);
      carry <= dsum[DIGIT];
      if (last) begin
        sum_q  <= acc_nxt;
        cout_q <= dsum[DIGIT];
        ovf_q  <= (a_msb == b_msb) && (acc_nxt[WIDTH-1] != a_msb);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
